// File: rtl/aes_pkg.sv
// Shared AES-128 constants and GF(2^8) / key-schedule helpers for the decrypt core.
package aes_pkg;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_EXPAND = 2'd1;
    localparam logic [1:0] S_ROUND  = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    function automatic logic [7:0] rcon(input logic [3:0] idx);
        case (idx)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254; 0 maps to 0 as the S-box requires.
    function automatic logic [7:0] ginv(input logic [7:0] a);
        logic [7:0] p;
        logic [7:0] r;
        p = a;
        r = 8'h01;
        for (int k = 1; k < 8; k++) begin
            p = gmul(p, p);
            r = gmul(r, p);
        end
        return r;
    endfunction

    // S-box computed as inverse followed by the FIPS-197 affine map.
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] i;
        i = ginv(a);
        return i ^ {i[6:0], i[7]} ^ {i[5:0], i[7:6]} ^ {i[4:0], i[7:5]} ^ {i[3:0], i[7:4]} ^ 8'h63;
    endfunction

    // Inverse affine map first, then field inverse.
    function automatic logic [7:0] inv_sbox(input logic [7:0] s);
        logic [7:0] t;
        t = {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05;
        return ginv(t);
    endfunction

    function automatic logic [31:0] sub_rot_word(input logic [31:0] w);
        return {sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0]), sbox(w[31:24])};
    endfunction

    function automatic logic [127:0] fwd_expand(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] w0, w1, w2, w3;
        w0 = k[127:96] ^ sub_rot_word(k[31:0]) ^ {rc, 24'h0};
        w1 = k[95:64] ^ w0;
        w2 = k[63:32] ^ w1;
        w3 = k[31:0]  ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    // Undo one expansion step: recover round key i-1 from round key i.
    function automatic logic [127:0] inv_expand(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] b0, b1, b2, b3;
        b3 = k[31:0]  ^ k[63:32];
        b2 = k[63:32] ^ k[95:64];
        b1 = k[95:64] ^ k[127:96];
        b0 = k[127:96] ^ sub_rot_word(b3) ^ {rc, 24'h0};
        return {b0, b1, b2, b3};
    endfunction

endpackage

// File: rtl/aes_inv_round_stage.sv
// One combinational inverse-cipher round: InvShiftRows, InvSubBytes, AddRoundKey, InvMixColumns.
module aes_inv_round_stage
    import aes_pkg::*;
(
    input  logic         disable_mix,
    input  logic [127:0] in_state,
    input  logic [127:0] round_key,
    output logic [127:0] out_state
);

    logic [127:0] shifted;
    logic [127:0] subbed;
    logic [127:0] keyed;
    logic [127:0] mixed;

    for (genvar c = 0; c < 4; c++) begin : g_col
        // Row r rotates right by r columns.
        for (genvar r = 0; r < 4; r++) begin : g_row
            localparam int DST = 4 * c + r;
            localparam int SRC = 4 * ((c + 4 - r) % 4) + r;
            assign shifted[127-8*DST -: 8] = in_state[127-8*SRC -: 8];
            assign subbed[127-8*DST -: 8]  = inv_sbox(shifted[127-8*DST -: 8]);
        end

        logic [7:0] s0, s1, s2, s3;
        assign s0 = keyed[127-32*c -: 8];
        assign s1 = keyed[119-32*c -: 8];
        assign s2 = keyed[111-32*c -: 8];
        assign s3 = keyed[103-32*c -: 8];

        assign mixed[127-32*c -: 32] = {
            gmul(s0, 8'h0e) ^ gmul(s1, 8'h0b) ^ gmul(s2, 8'h0d) ^ gmul(s3, 8'h09),
            gmul(s0, 8'h09) ^ gmul(s1, 8'h0e) ^ gmul(s2, 8'h0b) ^ gmul(s3, 8'h0d),
            gmul(s0, 8'h0d) ^ gmul(s1, 8'h09) ^ gmul(s2, 8'h0e) ^ gmul(s3, 8'h0b),
            gmul(s0, 8'h0b) ^ gmul(s1, 8'h0d) ^ gmul(s2, 8'h09) ^ gmul(s3, 8'h0e)
        };
    end

    assign keyed     = subbed ^ round_key;
    assign out_state = disable_mix ? keyed : mixed;

endmodule

// File: rtl/aes_decrypt_core.sv
// Iterative AES-128 decryptor: forward key expansion to round key 10, then one inverse round per cycle.
module aes_decrypt_core
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_key,
    input  logic [127:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data
);

    logic [1:0]   fsm_q, fsm_d;
    logic [3:0]   cnt_q, cnt_d;
    logic [127:0] key_q, key_d;
    logic [127:0] state_q, state_d;
    logic [127:0] out_q, out_d;
    logic         out_valid_q, out_valid_d;

    logic [127:0] rk_fwd;
    logic [127:0] rk_inv;
    logic [127:0] round_out;

    // In EXPAND cnt names the rcon being applied; in ROUND the key in key_q is round cnt+1.
    assign rk_fwd = fwd_expand(key_q, rcon(cnt_q));
    assign rk_inv = inv_expand(key_q, rcon(cnt_q + 4'd1));

    aes_inv_round_stage u_round (
        .disable_mix (cnt_q == 4'd0),
        .in_state    (state_q),
        .round_key   (rk_inv),
        .out_state   (round_out)
    );

    assign in_ready  = (fsm_q == S_IDLE) & ~rst;
    assign out_valid = out_valid_q;
    assign out_data  = out_q;

    // Next-state logic for the accept / expand / round / handoff sequence.
    always_comb begin
        fsm_d       = fsm_q;
        cnt_d       = cnt_q;
        key_d       = key_q;
        state_d     = state_q;
        out_d       = out_q;
        out_valid_d = out_valid_q;
        case (fsm_q)
            S_IDLE: begin
                if (in_valid && in_ready) begin
                    key_d   = in_key;
                    state_d = in_data;
                    cnt_d   = 4'd1;
                    fsm_d   = S_EXPAND;
                end
            end
            S_EXPAND: begin
                key_d = rk_fwd;
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'd10) begin
                    // Initial AddRoundKey uses round key 10 on the same edge it is produced.
                    state_d = state_q ^ rk_fwd;
                    cnt_d   = 4'd9;
                    fsm_d   = S_ROUND;
                end
            end
            S_ROUND: begin
                state_d = round_out;
                key_d   = rk_inv;
                cnt_d   = cnt_q - 4'd1;
                if (cnt_q == 4'd0) begin
                    out_d       = round_out;
                    out_valid_d = 1'b1;
                    cnt_d       = 4'd0;
                    fsm_d       = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    fsm_d       = S_IDLE;
                end
            end
            default: fsm_d = S_IDLE;
        endcase
    end

    // State registers; reset abandons any block in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q       <= S_IDLE;
            cnt_q       <= 4'd0;
            key_q       <= '0;
            state_q     <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            fsm_q       <= fsm_d;
            cnt_q       <= cnt_d;
            key_q       <= key_d;
            state_q     <= state_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
        end
    end

endmodule
